// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared constants for the E-stage multiply/divide unit.
//                Holds the 3-bit operation codes and the default latencies.
//  Revision    : 1.0  initial release
// ============================================================================
package mdu_pkg;

    // Operation codes carried on MDUOp
    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTLO  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MFLO  = 3'd6;
    localparam logic [2:0] MDU_MFHI  = 3'd7;

    // Default fixed latencies (must fit the 4-bit counter, max 15)
    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    // Arithmetic operations occupy codes 0..3, i.e. bit 2 clear
    function automatic logic is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module      : mdu
//  Description : Multiply/divide unit with HI/LO registers. Executes
//                mult/multu/div/divu as fixed-latency operations; serves
//                mthi/mtlo writes and mfhi/mflo reads.
//  Ports       : clk, reset (async, active-high)
//                MDUOp[2:0], MDU_start, A[31:0], B[31:0], req   (inputs)
//                busy, HI_out[31:0], LO_out[31:0], MDU_ans[31:0] (outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MDUOp,
    input  logic        MDU_start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        busy,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic [31:0] MDU_ans
);

    localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES);

    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] hi_n_q, hi_n_d, lo_n_q, lo_n_d;
    logic        wr_n_q, wr_n_d;        // pending result is to be committed

    logic        w_start;
    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_a_mag, w_b_mag, w_b_nz, w_bmag_nz;
    logic [31:0] w_qmag, w_rmag, w_q_s, w_r_s, w_q_u, w_r_u;

    assign busy    = (cnt_q != 4'd0);
    assign w_start = MDU_start & ~req & ~busy & is_arith(MDUOp);

    // Sign-extended operands make the low 64 bits equal the signed product
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'b0, A} * {32'b0, B};

    // Signed divide done on magnitudes so 0x80000000 / -1 is well defined:
    // |0x80000000| = 2^31 as unsigned, and negating 2^31 wraps back to itself.
    assign w_a_mag   = A[31] ? (~A + 32'd1) : A;
    assign w_b_mag   = B[31] ? (~B + 32'd1) : B;
    // Divisor forced to 1 on zero; the result is discarded in that case anyway
    assign w_bmag_nz = (B == 32'd0) ? 32'd1 : w_b_mag;
    assign w_b_nz    = (B == 32'd0) ? 32'd1 : B;
    assign w_qmag    = w_a_mag / w_bmag_nz;
    assign w_rmag    = w_a_mag % w_bmag_nz;
    assign w_q_s     = (A[31] ^ B[31]) ? (~w_qmag + 32'd1) : w_qmag;
    assign w_r_s     = A[31] ? (~w_rmag + 32'd1) : w_rmag;
    assign w_q_u     = A / w_b_nz;
    assign w_r_u     = A % w_b_nz;

    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        hi_n_d = hi_n_q;
        lo_n_d = lo_n_q;
        wr_n_d = wr_n_q;
        if (w_start) begin
            case (MDUOp)
                MDU_MULT: begin
                    {hi_n_d, lo_n_d} = w_prod_s;
                    wr_n_d = 1'b1;
                    cnt_d  = C_MULT_CNT;
                end
                MDU_MULTU: begin
                    {hi_n_d, lo_n_d} = w_prod_u;
                    wr_n_d = 1'b1;
                    cnt_d  = C_MULT_CNT;
                end
                MDU_DIV: begin
                    hi_n_d = w_r_s;
                    lo_n_d = w_q_s;
                    wr_n_d = (B != 32'd0);
                    cnt_d  = C_DIV_CNT;
                end
                default: begin
                    hi_n_d = w_r_u;
                    lo_n_d = w_q_u;
                    wr_n_d = (B != 32'd0);
                    cnt_d  = C_DIV_CNT;
                end
            endcase
        end else if (busy) begin
            // req is deliberately ignored here: the running op has committed
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1 && wr_n_q) begin
                hi_d = hi_n_q;
                lo_d = lo_n_q;
            end
        end else if (!req) begin
            if (MDUOp == MDU_MTLO) lo_d = A;
            if (MDUOp == MDU_MTHI) hi_d = A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= 4'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            hi_n_q <= 32'd0;
            lo_n_q <= 32'd0;
            wr_n_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            hi_n_q <= hi_n_d;
            lo_n_q <= lo_n_d;
            wr_n_q <= wr_n_d;
        end
    end

    assign HI_out  = hi_q;
    assign LO_out  = lo_q;
    assign MDU_ans = (MDUOp == MDU_MFHI) ? hi_q :
                     (MDUOp == MDU_MFLO) ? lo_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu
//  Description : Directed self-checking bench for mdu.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  MDUOp;
    logic        MDU_start;
    logic [31:0] A, B;
    logic        req;
    logic        busy;
    logic [31:0] HI_out, LO_out, MDU_ans;

    int n_cmp = 0;
    int n_err = 0;
    int len;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .MDUOp    (MDUOp),
        .MDU_start(MDU_start),
        .A        (A),
        .B        (B),
        .req      (req),
        .busy     (busy),
        .HI_out   (HI_out),
        .LO_out   (LO_out),
        .MDU_ans  (MDU_ans)
    );

    always #5 clk = ~clk;

    // The hazard unit never lets start or mt reach the unit while busy
    always @(posedge clk) begin
        if (!reset && busy === 1'b1) begin
            assert (!(MDU_start || MDUOp == MDU_MTLO || MDUOp == MDU_MTHI))
            else begin
                n_err++;
                $error("FAIL hazard_guarantee: start=%0b op=%0d while busy", MDU_start, MDUOp);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive for one cycle starting at a negedge; returns at the next negedge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic st, input logic rq);
        MDUOp = op; A = a; B = b; MDU_start = st; req = rq;
        @(negedge clk);
        MDU_start = 1'b0; req = 1'b0; MDUOp = MDU_MFLO;
    endtask

    // Counts negedges at which busy is high, bounded
    task automatic run_len(output int n);
        n = 0;
        while (busy === 1'b1 && n < 32) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        chk({tag, "_HI"}, HI_out, hi);
        chk({tag, "_LO"}, LO_out, lo);
        MDUOp = MDU_MFHI; #1;
        chk({tag, "_ans_hi"}, MDU_ans, hi);
        MDUOp = MDU_MFLO; #1;
        chk({tag, "_ans_lo"}, MDU_ans, lo);
    endtask

    initial begin
        reset = 1'b1; MDUOp = MDU_MFLO; MDU_start = 1'b0; A = '0; B = '0; req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        check_hilo("reset", 32'd0, 32'd0);

        // mult signed: -2 * 3 = -6
        issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
        chk("mult_hi_held_midrun", HI_out, 32'd0);
        run_len(len);
        chk("mult_len", len, 32'd5);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // multu: (2^32-1)^2
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_len(len);
        chk("multu_len", len, 32'd5);
        check_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        // div signed: -7 / 2 = -3 rem -1
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        run_len(len);
        chk("div_len", len, 32'd10);
        check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // div overflow corner
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_len(len);
        check_hilo("div_ovf", 32'h0000_0000, 32'h8000_0000);

        // divu: 100 / 7 = 14 rem 2
        issue(MDU_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
        run_len(len);
        chk("divu_len", len, 32'd10);
        check_hilo("divu", 32'd2, 32'd14);

        // mthi/mtlo preset, then divide by zero leaves them alone
        issue(MDU_MTHI, 32'h11, 32'd0, 1'b0, 1'b0);
        chk("mthi", HI_out, 32'h11);
        issue(MDU_MTLO, 32'h22, 32'd0, 1'b0, 1'b0);
        chk("mtlo", LO_out, 32'h22);
        issue(MDU_DIVU, 32'd5, 32'd0, 1'b1, 1'b0);
        run_len(len);
        chk("divz_len", len, 32'd10);
        check_hilo("divz", 32'h11, 32'h22);

        // req suppresses start and mt
        issue(MDU_MULT, 32'd3, 32'd4, 1'b1, 1'b1);
        chk("req_start_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_hilo("req_start", 32'h11, 32'h22);
        issue(MDU_MTLO, 32'h99, 32'd0, 1'b0, 1'b1);
        chk("req_mtlo", LO_out, 32'h22);

        // req during RUN does not disturb the operation: 6 * 7 = 42
        issue(MDU_MULT, 32'd6, 32'd7, 1'b1, 1'b0);
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        run_len(len);
        chk("req_run_len", len + 2, 32'd5);
        check_hilo("req_run", 32'd0, 32'd42);

        // reset mid-div when the counter reads 6
        issue(MDU_DIV, 32'd100, 32'd3, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("prereset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_hilo("rst_mid", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check_hilo("post_rst", 32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu.md
# mdu

Multiply/divide unit of the P7 pipeline, living in the E stage. It is the consumer of the decoder's `MDUOp`/`MDU_start` command and executes mult/multu/div/divu as fixed-latency multi-cycle operations. It also owns the HI and LO registers, serving mthi/mtlo writes and mfhi/mflo reads. A `busy` output feeds the hazard unit, which stalls any md/mt/mf instruction in D while `MDU_start | busy` is high.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `MDUOp`  in  3  — E-stage operation code (`MDU_*` macros in def.v).
- `MDU_start`  in  1  — one-cycle pulse; E-stage instruction is mult/multu/div/divu.
- `A`  in  32  — forwarded rs value.
- `B`  in  32  — forwarded rt value.
- `req`  in  1  — exception/interrupt taken this cycle; suppresses start and mt writes.
- `busy`  out  1  — operation in flight.
- `HI_out`  out  32  — HI register.
- `LO_out`  out  32  — LO register.
- `MDU_ans`  out  32  — read result: HI for `MDU_mfhi`, LO for `MDU_mflo`, else 0 (combinational).

## Operation
- Op codes (def.v): mult=0, multu=1, div=2, divu=3, mtlo=4, mthi=5, mflo=6, mfhi=7.
- **Reset:** HI=LO=0, busy=0, counter=0, pending results=0, so `MDU_ans`=0.
- **State:** IDLE (counter==0, busy=0) and RUN (counter>0, busy=1).
- **Start accept:** accepted at an edge where `MDU_start & !req & !busy`.
  - Operands are captured and the result is computed into pending regs `hi_n`/`lo_n`.
  - Counter loads `MULT_CYCLES` (ops 0/1) or `DIV_CYCLES` (ops 2/3).
- **RUN:**
  - Counter decrements each edge.
  - At the edge where the counter goes 1→0: HI←`hi_n`, LO←`lo_n`, busy→0.
- **Arithmetic:**
  - mult: 64-bit signed product; multu: 64-bit unsigned product. {HI,LO} = product.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. divu: unsigned.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- **Divide by zero (B==0):** runs the full `DIV_CYCLES`; HI/LO are left unchanged at completion.
- **mtlo/mthi:** at an edge with that `MDUOp` and `!req`, LO/HI ← `A`. Only legal when not busy.
- **Illegal inputs:**
  - `MDU_start` while busy: ignored.
  - mt while busy: ignored.
  - The hazard unit guarantees neither occurs; the bench asserts this.
- **req:** blocks a new start or mt write in the same cycle. An operation already in RUN is unaffected and completes normally, because it belongs to an instruction that has already committed.
- **Reset mid-operation:** aborts immediately. Returns to IDLE and clears HI/LO.

## Timing
- Start accepted at edge t:
  - busy=1 from t through t+N (N = parameter), busy=0 after edge t+N.
  - HI/LO hold the new values from edge t+N.
  - Stall coverage: during the start cycle itself `busy`=0, and the hazard unit covers it with `MDU_start`.
- mt write: visible on `HI_out`/`LO_out` the cycle after the edge.
- `MDU_ans`: zero-latency mux of the current HI/LO.
- No bypass: mf in the same cycle as a completing edge reads the old value. The stall makes this case unreachable.

## Structure
- def.v holds:
  - `MDU_mult`…`MDU_mfhi` opcode macros (3-bit).
  - `MDU_MULT_CYCLES`/`MDU_DIV_CYCLES` defaults.
- Single module; no sub-module needed.
  - Arithmetic uses inline Verilog `*`, `/`, `%` on `$signed` operands or 64-bit zero-extended operands.
  - Counter is 4 bits, sized for max(N) ≤ 15.

## Test plan
- **Reset:** assert reset mid-div (counter=6) → busy=0, HI=LO=0 immediately; `MDU_ans`=0.
- **mult signed:** A=0xFFFFFFFE, B=3 (mult) → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **multu:** A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- **div signed:** A=-7, B=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **divu by zero:** HI=0x11, LO=0x22 preset via mthi/mtlo, then divu A=5, B=0 → busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- **req suppression:**
  - mult start with req=1 → busy stays 0, HI/LO unchanged.
  - mtlo with req=1 → LO unchanged.
  - req pulsed during RUN → operation completes with the correct result.
